q_env_responder: RTL
====================

Q_ENV_RESPONDER -- requirements
Module: q_env_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning): GRID_ROWS 4 grid rows; GRID_COLS 4 grid columns; GOAL_ST 15 terminal goal state; OBSTACLE_MASK 16'h0020 one bit per blocked state; MAX_STEPS 8 episode step limit.
REQ-002 SHALL have ports (name direction width meaning), starting with: clk in 1 single clock, rising edge; rst_n in 1 asynchronous active-low reset.
REQ-003 SHALL have i_start in 1; pulse that begins a new episode.
REQ-004 SHALL have request ports: i_valid in 1 request valid; o_ready out 1 request accepted when high with i_valid; i_st in STATES_WIDTH current state; i_at in ACTIONS_WIDTH chosen action.
REQ-005 SHALL have response ports: o_valid out 1 response valid; i_ready in 1 consumer accepts response; o_next_st out STATES_WIDTH resulting state; o_rt out DATA_WIDTH signed reward; o_done out 1 episode terminated.

Function
REQ-006 SHALL act as the grid-world environment answering the agent controller: one (state, action) request in, one (next state, reward, done) response out.
REQ-007 SHALL decode state as row = st / GRID_COLS, col = st % GRID_COLS; actions 0 up (row-1), 1 right (col+1), 2 down (row+1), 3 left (col-1).
REQ-008 SHALL, on a move leaving the grid or entering a state whose OBSTACLE_MASK bit is set, return next_st = st and rt = REWARD_WALL.
REQ-009 SHALL, on a move into GOAL_ST, return next_st = GOAL_ST, rt = REWARD_GOAL, o_done = 1.
REQ-010 SHALL otherwise return the moved state and rt = REWARD_STEP, o_done = 0.
REQ-011 SHALL, for i_st >= GRID_ROWS*GRID_COLS, return next_st = 0, rt = REWARD_WALL, o_done = 1.
REQ-012 SHALL use FSM IDLE -> CALC -> RESP -> IDLE; o_ready = 1 only in IDLE.
REQ-013 SHALL capture i_st/i_at on the edge where i_valid & o_ready; go to CALC.
REQ-014 SHALL leave CALC unconditionally after one cycle; o_valid asserted 2 edges after acceptance.
REQ-015 SHALL hold o_valid and all response outputs stable in RESP until i_ready = 1; return to IDLE on that edge; o_valid low the following cycle.
REQ-016 SHALL ignore i_valid outside IDLE (no queuing).
REQ-017 SHALL give i_start priority over all transitions: next state IDLE, o_valid = 0, step counter = 0; any in-flight request is discarded.
REQ-018 SHALL compute rewards in signed DATA_WIDTH two's complement; constants sign-extended, no saturation needed.

Reset
REQ-019 SHALL, on rst_n low, asynchronously force: state IDLE, o_valid 0, o_next_st 0, o_rt 0, o_done 0, step counter 0; o_ready 1 once reset is released.
REQ-020 SHALL behave as REQ-017 if reset occurs mid-request; no response is emitted for that request.

Configuration
REQ-021 SHALL, with ENV_STEP_LIMIT_EN defined, count accepted requests since i_start/reset and force o_done = 1 on the response to the MAX_STEPS-th request; the counter saturates at MAX_STEPS.
REQ-022 SHALL, without ENV_STEP_LIMIT_EN, contain no step counter; o_done only per REQ-009/REQ-011.

Structure
REQ-023 SHALL take STATES_WIDTH, ACTIONS_WIDTH, DATA_WIDTH, REWARD_GOAL (100), REWARD_WALL (-10), REWARD_STEP (-1) and the action encodings from the shared params.sv.
REQ-024 SHALL place the move/reward evaluation in one combinational sub-module env_grid_step; FSM, registers and the counter stay in q_env_responder.

Verification (4x4 grid, defaults)
REQ-025 st=0, at=0 -> o_next_st=0, o_rt=-10, o_done=0; o_valid exactly 2 edges after acceptance.
REQ-026 st=14, at=1 -> o_next_st=15, o_rt=100, o_done=1; st=1, at=2 (obstacle 5) -> o_next_st=1, o_rt=-10.
REQ-027 i_ready held low 3 cycles in RESP with a second i_valid present -> outputs stable, o_ready=0, second request accepted only after return to IDLE.
REQ-028 i_start pulsed in CALC -> o_valid never asserts for that request; next request is treated as step 1.
REQ-029 ENV_STEP_LIMIT_EN: 8 requests st=4, at=3 -> responses 1-7 o_done=0, response 8 o_done=1, o_rt=-10; without macro all 8 o_done=0.

Source files
------------

// File: rtl/q_env_responder_pkg.sv
// Shared environment parameters for the grid-world responder: bus widths,
// signed reward constants, action encodings and the responder FSM states.
package q_env_responder_pkg;

   localparam int STATES_WIDTH  = 8;
   localparam int ACTIONS_WIDTH = 2;
   localparam int DATA_WIDTH    = 16;

   // Rewards are two's complement at DATA_WIDTH; the size cast sign-extends.
   localparam logic signed [DATA_WIDTH-1:0] REWARD_GOAL = DATA_WIDTH'(100);
   localparam logic signed [DATA_WIDTH-1:0] REWARD_WALL = DATA_WIDTH'(-10);
   localparam logic signed [DATA_WIDTH-1:0] REWARD_STEP = DATA_WIDTH'(-1);

   typedef enum logic [ACTIONS_WIDTH-1:0] {
      ACT_UP    = 2'd0,
      ACT_RIGHT = 2'd1,
      ACT_DOWN  = 2'd2,
      ACT_LEFT  = 2'd3
   } action_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } fsm_e;

endpackage

// File: rtl/q_env_responder_env_grid_step.sv
// env_grid_step: purely combinational move/reward evaluation for one
// (state, action) pair on a GRID_ROWS x GRID_COLS grid with obstacles.
module env_grid_step
   import q_env_responder_pkg::*;
#(
   parameter int                               GRID_ROWS     = 4,
   parameter int                               GRID_COLS     = 4,
   parameter int                               GOAL_ST       = 15,
   parameter logic [GRID_ROWS*GRID_COLS-1:0]   OBSTACLE_MASK = 16'h0020
) (
   input  logic [STATES_WIDTH-1:0]         i_st,
   input  logic [ACTIONS_WIDTH-1:0]        i_at,
   output logic [STATES_WIDTH-1:0]         o_next_st,
   output logic signed [DATA_WIDTH-1:0]    o_rt,
   output logic                            o_done
);

   localparam int NSTATES = GRID_ROWS * GRID_COLS;

   int   w_row;
   int   w_col;
   int   w_nrow;
   int   w_ncol;
   int   w_tgt;
   logic w_off_grid;
   logic w_blocked;

   // Decode row/col, apply the move, then classify: off-grid/obstacle, goal, plain step.
   always_comb begin
      o_next_st  = i_st;
      o_rt       = REWARD_WALL;
      o_done     = 1'b0;
      w_row      = 0;
      w_col      = 0;
      w_nrow     = 0;
      w_ncol     = 0;
      w_tgt      = 0;
      w_off_grid = 1'b0;
      w_blocked  = 1'b0;
      if (int'(i_st) >= NSTATES) begin
         // A state outside the grid is unrecoverable: restart from 0 and end.
         o_next_st = '0;
         o_rt      = REWARD_WALL;
         o_done    = 1'b1;
      end else begin
         w_row  = int'(i_st) / GRID_COLS;
         w_col  = int'(i_st) % GRID_COLS;
         w_nrow = w_row;
         w_ncol = w_col;
         case (action_e'(i_at))
            ACT_UP:    w_nrow = w_row - 1;
            ACT_RIGHT: w_ncol = w_col + 1;
            ACT_DOWN:  w_nrow = w_row + 1;
            ACT_LEFT:  w_ncol = w_col - 1;
            default:   w_nrow = w_row;
         endcase
         w_off_grid = (w_nrow < 0) || (w_nrow >= GRID_ROWS) ||
                      (w_ncol < 0) || (w_ncol >= GRID_COLS);
         if (!w_off_grid) begin
            w_tgt     = w_nrow * GRID_COLS + w_ncol;
            w_blocked = |(OBSTACLE_MASK & (NSTATES'(1) << w_tgt));
         end
         if (w_off_grid || w_blocked) begin
            o_next_st = i_st;
            o_rt      = REWARD_WALL;
         end else if (w_tgt == GOAL_ST) begin
            o_next_st = STATES_WIDTH'(GOAL_ST);
            o_rt      = REWARD_GOAL;
            o_done    = 1'b1;
         end else begin
            o_next_st = STATES_WIDTH'(w_tgt);
            o_rt      = REWARD_STEP;
         end
      end
   end

endmodule

// File: rtl/q_env_responder.sv
// q_env_responder: grid-world environment answering one (state, action)
// request with one registered (next state, reward, done) response.
// Optional build macro ENV_STEP_LIMIT_EN adds an episode step limit that
// forces done on the response to the MAX_STEPS-th accepted request.
module q_env_responder
   import q_env_responder_pkg::*;
#(
   parameter int                               GRID_ROWS     = 4,
   parameter int                               GRID_COLS     = 4,
   parameter int                               GOAL_ST       = 15,
   parameter logic [GRID_ROWS*GRID_COLS-1:0]   OBSTACLE_MASK = 16'h0020,
   parameter int                               MAX_STEPS     = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_start,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic [STATES_WIDTH-1:0]         i_st,
   input  logic [ACTIONS_WIDTH-1:0]        i_at,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [STATES_WIDTH-1:0]         o_next_st,
   output logic signed [DATA_WIDTH-1:0]    o_rt,
   output logic                            o_done
);

   fsm_e                          r_state;
   fsm_e                          w_state_next;
   logic                          w_accept;
   logic                          w_limit;
   logic [STATES_WIDTH-1:0]       r_st;
   logic [ACTIONS_WIDTH-1:0]      r_at;
   logic [STATES_WIDTH-1:0]       r_next_st;
   logic signed [DATA_WIDTH-1:0]  r_rt;
   logic                          r_done;
   logic [STATES_WIDTH-1:0]       w_next_st;
   logic signed [DATA_WIDTH-1:0]  w_rt;
   logic                          w_done;

   if (MAX_STEPS < 1 || GOAL_ST >= GRID_ROWS * GRID_COLS) begin : g_param_check
      $error("q_env_responder: MAX_STEPS must be >= 1 and GOAL_ST inside the grid");
   end

   // A request arriving together with i_start is refused so it is not silently lost.
   assign o_ready  = (r_state == ST_IDLE) && !i_start;
   assign w_accept = i_valid && o_ready;
   assign o_valid  = (r_state == ST_RESP);

   env_grid_step #(
      .GRID_ROWS     (GRID_ROWS),
      .GRID_COLS     (GRID_COLS),
      .GOAL_ST       (GOAL_ST),
      .OBSTACLE_MASK (OBSTACLE_MASK)
   ) u_grid_step (
      .i_st      (r_st),
      .i_at      (r_at),
      .o_next_st (w_next_st),
      .o_rt      (w_rt),
      .o_done    (w_done)
   );

`ifdef ENV_STEP_LIMIT_EN
   localparam int STEP_W = $clog2(MAX_STEPS + 1);
   logic [STEP_W-1:0] r_steps;

   // Count accepted requests since start/reset, saturating at MAX_STEPS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_steps <= '0;
      end else if (i_start) begin
         r_steps <= '0;
      end else if (w_accept && (r_steps != STEP_W'(MAX_STEPS))) begin
         r_steps <= r_steps + 1'b1;
      end
   end

   // In CALC the counter already includes the request being evaluated.
   assign w_limit = (r_steps == STEP_W'(MAX_STEPS));
`else
   assign w_limit = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: IDLE -> CALC on accept, CALC -> RESP, RESP -> IDLE on i_ready; i_start aborts.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_next = ST_CALC;
         ST_CALC: w_state_next = ST_RESP;
         ST_RESP: if (i_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
      if (i_start) begin
         w_state_next = ST_IDLE;
      end
   end

   // Capture the request on accept; register the evaluated response in CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st      <= '0;
         r_at      <= '0;
         r_next_st <= '0;
         r_rt      <= '0;
         r_done    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_st <= i_st;
            r_at <= i_at;
         end
         if ((r_state == ST_CALC) && !i_start) begin
            r_next_st <= w_next_st;
            r_rt      <= w_rt;
            r_done    <= w_done | w_limit;
         end
      end
   end

   assign o_next_st = r_next_st;
   assign o_rt      = r_rt;
   assign o_done    = r_done;

endmodule
